// File: rtl/seq_shift_mult.sv
// -----------------------------------------------------------------------------
// seq_shift_mult
//
// Iterative shift-add multiplier. It takes an unsigned AW-bit multiplicand and
// an unsigned BW-bit multiplier and returns their exact (AW+BW)-bit product.
// The datapath is a single (AW+BW)-bit adder plus shift registers.
//
// Operation: one iteration per clock in RUN. Each iteration consumes the
// multiplier's LSB, adds the shifted multiplicand when that bit is set, and
// then shifts. Operands and results use independent valid/ready handshakes.
// Accept and output never overlap.
//
// Optional build macro:
//   SEQ_SHIFT_MULT_EARLY_TERM_EN - leave RUN as soon as the remaining
//   multiplier bits are all zero, so latency is (index of B's top set bit)+1,
//   with a minimum of 1. The product value is the same in both builds.
//
// Ports:
//   CLK        in   rising-edge clock
//   RST_N      in   asynchronous active-low reset
//   IN_VALID   in   operand pair valid
//   IN_READY   out  high in IDLE (block can accept operands)
//   A          in   [AW-1:0] multiplicand, unsigned
//   B          in   [BW-1:0] multiplier, unsigned
//   OUT_VALID  out  high in DONE (PROD valid)
//   OUT_READY  in   consumer accepts PROD
//   PROD       out  [AW+BW-1:0] product, holds until the next result
//   BUSY       out  high in RUN or DONE
// -----------------------------------------------------------------------------
module seq_shift_mult #(
    parameter int AW = 17,
    parameter int BW = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [AW-1:0]    A,
    input  logic [BW-1:0]    B,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [AW+BW-1:0] PROD,
    output logic             BUSY
);

    localparam int PW = AW + BW;
    localparam int CW = (BW > 1) ? $clog2(BW) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [PW-1:0] mcand_q, mcand_d;
    logic [BW-1:0] mult_q,  mult_d;
    logic [PW-1:0] acc_q,   acc_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic [PW-1:0] prod_q,  prod_d;

    // Accumulator value after this edge's conditional add. It is also the
    // final product on the last iteration.
    logic [PW-1:0] acc_add;
    logic [BW-1:0] mult_shr;
    logic          last_iter;

    always_comb begin
        acc_add  = mult_q[0] ? (acc_q + mcand_q) : acc_q;
        mult_shr = mult_q >> 1;
`ifdef SEQ_SHIFT_MULT_EARLY_TERM_EN
        // Once the remaining multiplier bits are all zero, further
        // iterations cannot change acc, so stop early.
        last_iter = (cnt_q == CW'(BW - 1)) || (mult_shr == '0);
`else
        last_iter = (cnt_q == CW'(BW - 1));
`endif
    end

    always_comb begin
        state_d = state_q;
        mcand_d = mcand_q;
        mult_d  = mult_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;

        case (state_q)
            ST_IDLE: begin
                if (IN_VALID) begin
                    mcand_d = {{BW{1'b0}}, A};
                    mult_d  = B;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                acc_d   = acc_add;
                mcand_d = mcand_q << 1;
                mult_d  = mult_shr;
                cnt_d   = cnt_q + CW'(1);
                if (last_iter) begin
                    prod_d  = acc_add;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (OUT_READY) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            mcand_q <= '0;
            mult_q  <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            mcand_q <= mcand_d;
            mult_q  <= mult_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
        end
    end

    // All outputs are decoded from state or come straight from flops.
    assign IN_READY  = (state_q == ST_IDLE);
    assign OUT_VALID = (state_q == ST_DONE);
    assign BUSY      = (state_q != ST_IDLE);
    assign PROD      = prod_q;

endmodule

// File: tb/tb_seq_shift_mult.sv
module tb_seq_shift_mult;

    localparam int AW = 17;
    localparam int BW = 16;
    localparam int PW = AW + BW;

    // Expected accept-to-OUT_VALID latency for each B used below.
`ifdef SEQ_SHIFT_MULT_EARLY_TERM_EN
    localparam int LAT_B5    = 3;
    localparam int LAT_BFFFF = 16;
    localparam int LAT_B567  = 10;
    localparam int LAT_B9    = 4;
    localparam int LAT_B1    = 1;
    localparam int LAT_B0    = 1;
`else
    localparam int LAT_B5    = 16;
    localparam int LAT_BFFFF = 16;
    localparam int LAT_B567  = 16;
    localparam int LAT_B9    = 16;
    localparam int LAT_B1    = 16;
    localparam int LAT_B0    = 16;
`endif

    logic          CLK;
    logic          RST_N;
    logic          IN_VALID;
    logic          IN_READY;
    logic [AW-1:0] A;
    logic [BW-1:0] B;
    logic          OUT_VALID;
    logic          OUT_READY;
    logic [PW-1:0] PROD;
    logic          BUSY;

    int checks   = 0;
    int failures = 0;

    seq_shift_mult #(.AW(AW), .BW(BW)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .A         (A),
        .B         (B),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .PROD      (PROD),
        .BUSY      (BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Present one operand pair for a single edge. The caller has already
    // checked that IN_READY is high.
    task automatic accept(input logic [AW-1:0] a, input logic [BW-1:0] b);
        IN_VALID = 1'b1;
        A        = a;
        B        = b;
        step();
        IN_VALID = 1'b0;
    endtask

    // Count edges until OUT_VALID is seen; -1 if the bound expires.
    task automatic wait_out(output int lat);
        lat = -1;
        for (int i = 1; i <= 100; i++) begin
            step();
            if (OUT_VALID) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        RST_N     = 1'b0;
        IN_VALID  = 1'b0;
        OUT_READY = 1'b0;
        A         = '0;
        B         = '0;
        #12;
        checks++; if (IN_READY !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", IN_READY); end
        checks++; if (OUT_VALID !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", OUT_VALID); end
        checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", BUSY); end
        checks++; if (PROD !== '0) begin failures++; $display("FAIL reset_prod got=%h exp=0", PROD); end
        @(negedge CLK);
        RST_N = 1'b1;
        step();
    endtask

    task automatic test_basic();
        int lat;
        OUT_READY = 1'b1;
        accept(17'd3, 16'd5);
        checks++; if (BUSY !== 1'b1) begin failures++; $display("FAIL basic_busy got=%b exp=1", BUSY); end
        wait_out(lat);
        checks++; if (lat != LAT_B5) begin failures++; $display("FAIL basic_latency got=%0d exp=%0d", lat, LAT_B5); end
        checks++; if (PROD !== 33'd15) begin failures++; $display("FAIL basic_prod got=%0d exp=15", PROD); end
        step();
        checks++; if (OUT_VALID !== 1'b0) begin failures++; $display("FAIL basic_valid_1cyc got=%b exp=0", OUT_VALID); end
        checks++; if (IN_READY !== 1'b1) begin failures++; $display("FAIL basic_in_ready got=%b exp=1", IN_READY); end
    endtask

    task automatic test_max();
        int lat;
        OUT_READY = 1'b1;
        accept(17'h1FFFF, 16'hFFFF);
        wait_out(lat);
        checks++; if (lat != LAT_BFFFF) begin failures++; $display("FAIL max_latency got=%0d exp=%0d", lat, LAT_BFFFF); end
        checks++; if (PROD !== 33'h1FFFD0001) begin failures++; $display("FAIL max_prod got=%h exp=1fffd0001", PROD); end
        step();
    endtask

    task automatic test_backpressure();
        int lat;
        OUT_READY = 1'b0;
        accept(17'd1234, 16'd567);
        // Junk operands held valid through RUN and DONE must be ignored.
        IN_VALID = 1'b1;
        A        = 17'd7;
        B        = 16'd7;
        checks++; if (IN_READY !== 1'b0) begin failures++; $display("FAIL bp_in_ready_run got=%b exp=0", IN_READY); end
        wait_out(lat);
        checks++; if (lat != LAT_B567) begin failures++; $display("FAIL bp_latency got=%0d exp=%0d", lat, LAT_B567); end
        for (int i = 0; i < 5; i++) begin
            checks++; if (OUT_VALID !== 1'b1 || PROD !== 33'd699678 || IN_READY !== 1'b0)
                begin failures++; $display("FAIL bp_hold cyc=%0d valid=%b prod=%0d in_ready=%b exp=1/699678/0", i, OUT_VALID, PROD, IN_READY); end
            step();
        end
        IN_VALID  = 1'b0;
        OUT_READY = 1'b1;
        step();
        checks++; if (OUT_VALID !== 1'b0) begin failures++; $display("FAIL bp_release_valid got=%b exp=0", OUT_VALID); end
        checks++; if (IN_READY !== 1'b1) begin failures++; $display("FAIL bp_release_in_ready got=%b exp=1", IN_READY); end
        checks++; if (PROD !== 33'd699678) begin failures++; $display("FAIL bp_prod_kept got=%0d exp=699678", PROD); end
    endtask

    task automatic test_reset_mid();
        int lat;
        OUT_READY = 1'b1;
        accept(17'd5, 16'hFFFF);
        for (int i = 0; i < 7; i++) step();
        checks++; if (BUSY !== 1'b1) begin failures++; $display("FAIL rst_mid_busy_before got=%b exp=1", BUSY); end
        RST_N = 1'b0;
        #1;
        checks++; if (OUT_VALID !== 1'b0 || IN_READY !== 1'b1 || BUSY !== 1'b0)
            begin failures++; $display("FAIL rst_mid_ctrl valid=%b in_ready=%b busy=%b exp=0/1/0", OUT_VALID, IN_READY, BUSY); end
        checks++; if (PROD !== '0) begin failures++; $display("FAIL rst_mid_prod got=%0d exp=0", PROD); end
        @(negedge CLK);
        RST_N = 1'b1;
        step();
        checks++; if (OUT_VALID !== 1'b0 || IN_READY !== 1'b1) begin failures++; $display("FAIL rst_mid_after valid=%b in_ready=%b exp=0/1", OUT_VALID, IN_READY); end
        accept(17'd2, 16'd9);
        wait_out(lat);
        checks++; if (lat != LAT_B9) begin failures++; $display("FAIL rst_mid_next_latency got=%0d exp=%0d", lat, LAT_B9); end
        checks++; if (PROD !== 33'd18) begin failures++; $display("FAIL rst_mid_next_prod got=%0d exp=18", PROD); end
        step();
    endtask

    task automatic test_early_term();
        int lat;
        OUT_READY = 1'b1;
        accept(17'd100, 16'h0001);
        wait_out(lat);
        checks++; if (lat != LAT_B1) begin failures++; $display("FAIL et_b1_latency got=%0d exp=%0d", lat, LAT_B1); end
        checks++; if (PROD !== 33'd100) begin failures++; $display("FAIL et_b1_prod got=%0d exp=100", PROD); end
        step();
        accept(17'd100, 16'h0000);
        wait_out(lat);
        checks++; if (lat != LAT_B0) begin failures++; $display("FAIL et_b0_latency got=%0d exp=%0d", lat, LAT_B0); end
        checks++; if (PROD !== 33'd0) begin failures++; $display("FAIL et_b0_prod got=%0d exp=0", PROD); end
        step();
    endtask

    task automatic test_back_to_back();
        int lat;
        OUT_READY = 1'b1;
        accept(17'd40000, 16'd3);
        wait_out(lat);
        checks++; if (PROD !== 33'd120000) begin failures++; $display("FAIL b2b_first_prod got=%0d exp=120000", PROD); end
        // Handshake completes on this edge; next pair is accepted on the one after.
        step();
        checks++; if (IN_READY !== 1'b1) begin failures++; $display("FAIL b2b_in_ready got=%b exp=1", IN_READY); end
        accept(17'h10000, 16'h8000);
        wait_out(lat);
        checks++; if (lat != 16) begin failures++; $display("FAIL b2b_second_latency got=%0d exp=16", lat); end
        checks++; if (PROD !== 33'h080000000) begin failures++; $display("FAIL b2b_second_prod got=%h exp=080000000", PROD); end
        step();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_max();
        test_backpressure();
        test_reset_mid();
        test_early_term();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
